output_vc_credit_arbiter: RTL
=============================

# output_vc_credit_arbiter

Output-port stage of a router, parametrised in input count and virtual-channel count. It arbitrates flits from N_INPUTS input modules onto one output link. It adds per-VC wormhole locking, credit-based flow control towards the downstream buffer and a registered output stage. It replaces ready-based output muxing on links whose downstream has fixed per-VC buffer depth.

## Interface
- N_INPUTS, 5: number of input modules feeding this output (≥2).
- N_VIRT_CHN, 2: virtual channels (≥1); VC index width VC_W = max(1,$clog2(N_VIRT_CHN)).
- CREDIT_DEPTH, 4: downstream buffer slots per VC; counter width CW = $clog2(CREDIT_DEPTH+1).
- H_PRIORITY, 1: VC selection when VC_RR=0; 1 = highest VC index wins, 0 = lowest wins.
- VC_RR, 0: 1 = round-robin among eligible VCs per flit, ignoring H_PRIORITY.

Ports:
- clk  in  1  clock.
- arst  in  1  reset. Synchronous, active-high: sampled only on the rising edge of clk.
- fin_req_i  in  s_flit_req_t[N_INPUTS]  flit, valid, vc_id from each input module.
- fin_resp_o  out  s_flit_resp_t[N_INPUTS]  ready per input. At most one is high per cycle.
- fout_req_o  out  s_flit_req_t  registered flit, valid, vc_id to downstream.
- credit_i  in  N_VIRT_CHN  one-cycle pulse per VC: downstream freed one slot.
- credit_err_o  out  1  sticky; set on credit overflow.

## Operation
- Flit decode: fdata is read as s_flit_head_data_t. Head = type_f==HEAD_FLIT. Tail = type_f==TAIL_FLIT. Single-flit packet = head with pkt_size==MIN_SIZE_FLIT.
- Per-VC lock state: locked bit plus owner index. When locked, only the owner's flits on that VC are eligible for that VC.
- Lock set when a non-single head is accepted on VC v; owner = accepting input.
- Lock cleared when the owner's tail is accepted on v.
- Single-flit packets never lock.
- Per-VC input arbitration, unlocked VCs only: the rr_arbiter picks among inputs with valid && vc_id==v.
  - Arbiter pointer updates only when a head is accepted on v.
  - Body and tail flits from a non-owner are never granted.
- VC eligible when it has a granted or owner-valid input and credit[v] > 0.
- VC selection among eligible VCs:
  - VC_RR=0: fixed priority per H_PRIORITY.
  - VC_RR=1: round-robin; pointer advances past the winner on each accepted flit.
- Flits of different VCs may interleave cycle by cycle. Locks are per VC.
- Accept: fin_resp_o[w].ready=1 for the winner input w only. ready is combinational from valid, lock and credit. Acceptance = valid && ready.
- Credits:
  - credit[v] decrements on acceptance of a v flit; increments on credit_i[v].
  - Both in the same cycle → unchanged.
  - Increment at CREDIT_DEPTH with no decrement: saturate and set credit_err_o.
- No credit on any VC with pending flits: all ready low, fout valid low, locks held.

## Timing
- Reset values:
  - fout_req_o = '0.
  - All fin_resp_o ready = 0 during arst.
  - credit[v] = CREDIT_DEPTH.
  - All locks cleared; arbiter pointers at input 0 / VC 0.
  - credit_err_o = 0.
- Latency: a flit accepted in cycle t is presented on fout_req_o in cycle t+1 for exactly one cycle (valid=1, vc_id = VC of the flit). No acceptance in t → valid=0 in t+1.
- Throughput: one flit per cycle while credit is available.
- Credit pulse in cycle t is usable for acceptance in cycle t+1.
- Reset asserted mid-packet: all state returns to reset values at the next edge. The partial packet is abandoned. Upstream resynchronisation is outside this block.
- credit_err_o clears only on reset.

## Structure
- Shared package ravenoc_pkg provides s_flit_req_t, s_flit_resp_t, s_flit_head_data_t, HEAD_FLIT/BODY_FLIT/TAIL_FLIT and MIN_SIZE_FLIT.
- Add to the package a default CREDIT_DEPTH constant and a s_vc_lock_t typedef (locked bit, owner index).
- Sub-module: rr_arbiter (N_OF_INPUTS, update_i, req_i, grant_o). One instance per VC for inputs, plus one N_VIRT_CHN-wide instance used when VC_RR=1.

## Test plan
- N_INPUTS=5, N_VIRT_CHN=2, CREDIT_DEPTH=4. Input 1 sends a 3-flit packet on VC0 while input 3 sends a head on VC0 → input 1's head, body and tail appear on fout in cycles t+1..t+3. Input 3 is granted only after the tail.
- Single-flit packets from inputs 0, 2 and 4 on VC1, no credit_i → accepted in RR order 0,2,4; credit[1]=1 afterwards; no lock set.
- 6 back-to-back flits on VC0 with no credit_i → 4 accepted, then ready=0. A credit_i[0] pulse in cycle k → one flit accepted in k+1.
- H_PRIORITY=1, VC_RR=0, both VCs requesting with credit → VC1 flits win every cycle until VC1 has no flit or no credit.
- VC_RR=1, both VCs requesting → fout vc_id alternates 0,1,0,1.
- credit_i[0] pulsed at full credit → credit_err_o=1 and stays 1. Reset asserted mid-packet → next cycle fout valid=0, credits=4, lock cleared.

Source files
------------

// File: rtl/ravenoc_pkg.sv
// Shared router types: flit request/response, head-flit decode view, and
// the per-VC wormhole lock record used by the output stage.
package ravenoc_pkg;

    localparam int FLIT_WIDTH       = 34;
    localparam int VC_WIDTH         = 2;
    localparam int PKT_SIZE_WIDTH   = 8;
    localparam int OWNER_WIDTH      = 4;
    localparam int DEF_CREDIT_DEPTH = 4;

    localparam logic [PKT_SIZE_WIDTH-1:0] MIN_SIZE_FLIT = 8'd0;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'd0,
        BODY_FLIT = 2'd1,
        TAIL_FLIT = 2'd2
    } flit_type_t;

    typedef struct packed {
        flit_type_t                type_f;
        logic [1:0]                x_dest;
        logic [1:0]                y_dest;
        logic [PKT_SIZE_WIDTH-1:0] pkt_size;
        logic [19:0]               data;
    } s_flit_head_data_t;

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] fdata;
        logic                  valid;
        logic [VC_WIDTH-1:0]   vc_id;
    } s_flit_req_t;

    typedef struct packed {
        logic ready;
    } s_flit_resp_t;

    typedef struct packed {
        logic                   locked;
        logic [OWNER_WIDTH-1:0] owner;
    } s_vc_lock_t;

    function automatic logic flit_is_head(input logic [FLIT_WIDTH-1:0] fdata);
        s_flit_head_data_t h;
        h = fdata;
        return (h.type_f == HEAD_FLIT);
    endfunction

    function automatic logic flit_is_tail(input logic [FLIT_WIDTH-1:0] fdata);
        s_flit_head_data_t h;
        h = fdata;
        return (h.type_f == TAIL_FLIT);
    endfunction

    // A head carrying the minimum size is a whole packet and never locks a VC.
    function automatic logic flit_is_single(input logic [FLIT_WIDTH-1:0] fdata);
        s_flit_head_data_t h;
        h = fdata;
        return (h.type_f == HEAD_FLIT) && (h.pkt_size == MIN_SIZE_FLIT);
    endfunction

endpackage

// File: rtl/output_vc_credit_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting from a pointer
// that moves just past the granted requester whenever update_i is high.
module rr_arbiter #(
    parameter int N_OF_INPUTS = 2
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   update_i,
    input  logic [N_OF_INPUTS-1:0] req_i,
    output logic [N_OF_INPUTS-1:0] grant_o
);

    localparam int PW = (N_OF_INPUTS > 1) ? $clog2(N_OF_INPUTS) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;
    logic          found;
    int            scan_idx;

    // Scan requesters starting at the pointer, first hit wins.
    always_comb begin
        grant_o   = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan_idx  = 0;
        for (int o = 0; o < N_OF_INPUTS; o++) begin
            scan_idx = int'(ptr) + o;
            if (scan_idx >= N_OF_INPUTS) begin
                scan_idx = scan_idx - N_OF_INPUTS;
            end else begin
                scan_idx = scan_idx;
            end
            if (!found && req_i[scan_idx]) begin
                found              = 1'b1;
                grant_o[scan_idx]  = 1'b1;
                grant_idx          = PW'(scan_idx);
            end else begin
                found = found;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (arst) begin
            ptr <= '0;
        end else if (update_i && found) begin
            if (grant_idx == PW'(N_OF_INPUTS - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + PW'(1);
            end
        end else begin
            ptr <= ptr;
        end
    end

endmodule

// File: rtl/output_vc_credit_arbiter.sv
// Router output stage: per-VC wormhole locking, per-VC input round-robin,
// VC selection, credit flow control and a registered output flit.
module output_vc_credit_arbiter
    import ravenoc_pkg::*;
#(
    parameter int N_INPUTS     = 5,
    parameter int N_VIRT_CHN   = 2,
    parameter int CREDIT_DEPTH = DEF_CREDIT_DEPTH,
    parameter bit H_PRIORITY   = 1'b1,
    parameter bit VC_RR        = 1'b0
) (
    input  logic                         clk,
    input  logic                         arst,
    input  s_flit_req_t  [N_INPUTS-1:0]  fin_req_i,
    output s_flit_resp_t [N_INPUTS-1:0]  fin_resp_o,
    output s_flit_req_t                  fout_req_o,
    input  logic [N_VIRT_CHN-1:0]        credit_i,
    output logic                         credit_err_o
);

    localparam int VC_W = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1;
    localparam int CW   = $clog2(CREDIT_DEPTH + 1);
    localparam int IW   = $clog2(N_INPUTS);

    logic [CW-1:0]       credit    [N_VIRT_CHN];
    s_vc_lock_t          lock      [N_VIRT_CHN];
    logic [N_INPUTS-1:0] head_req  [N_VIRT_CHN];
    logic [N_INPUTS-1:0] arb_grant [N_VIRT_CHN];
    logic [IW-1:0]       cand_idx  [N_VIRT_CHN];

    logic [N_VIRT_CHN-1:0] arb_update;
    logic [N_VIRT_CHN-1:0] cand_valid;
    logic [N_VIRT_CHN-1:0] eligible;
    logic [N_VIRT_CHN-1:0] vc_grant;
    logic [N_VIRT_CHN-1:0] credit_dec;
    logic [N_VIRT_CHN-1:0] overflow;

    logic              accept;
    logic [VC_W-1:0]   sel_vc;
    logic [IW-1:0]     win_idx;
    s_flit_req_t       win_flit;
    logic              win_head;
    logic              win_tail;
    logic              win_single;

    // Heads per VC feed the input arbiters; only heads may open a packet.
    always_comb begin
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                head_req[v][i] = fin_req_i[i].valid
                               && (fin_req_i[i].vc_id == VC_WIDTH'(v))
                               && flit_is_head(fin_req_i[i].fdata);
            end
        end
    end

    for (genvar gv = 0; gv < N_VIRT_CHN; gv++) begin : g_in_arb
        rr_arbiter #(.N_OF_INPUTS(N_INPUTS)) u_in_arb (
            .clk      (clk),
            .arst     (arst),
            .update_i (arb_update[gv]),
            .req_i    (head_req[gv]),
            .grant_o  (arb_grant[gv])
        );
    end

    // Locked VCs only listen to their owner; unlocked ones take the arbiter's pick.
    always_comb begin
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            cand_valid[v] = 1'b0;
            cand_idx[v]   = '0;
            for (int i = 0; i < N_INPUTS; i++) begin
                if (lock[v].locked) begin
                    if ((lock[v].owner == OWNER_WIDTH'(i)) && fin_req_i[i].valid
                        && (fin_req_i[i].vc_id == VC_WIDTH'(v))) begin
                        cand_valid[v] = 1'b1;
                        cand_idx[v]   = IW'(i);
                    end else begin
                        cand_valid[v] = cand_valid[v];
                    end
                end else if (arb_grant[v][i]) begin
                    cand_valid[v] = 1'b1;
                    cand_idx[v]   = IW'(i);
                end else begin
                    cand_valid[v] = cand_valid[v];
                end
            end
            eligible[v] = cand_valid[v] && (credit[v] != '0);
        end
    end

    if (VC_RR) begin : g_vc_rr
        rr_arbiter #(.N_OF_INPUTS(N_VIRT_CHN)) u_vc_arb (
            .clk      (clk),
            .arst     (arst),
            .update_i (accept),
            .req_i    (eligible),
            .grant_o  (vc_grant)
        );
    end else begin : g_vc_fixed
        assign vc_grant = '0;
    end

    // Pick the winning VC, then the winning input and its flit.
    always_comb begin
        accept   = 1'b0;
        sel_vc   = '0;
        win_idx  = '0;
        win_flit = '0;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            if (VC_RR) begin
                if (vc_grant[v]) begin
                    accept = 1'b1;
                    sel_vc = VC_W'(v);
                end else begin
                    accept = accept;
                end
            end else if (eligible[v] && (H_PRIORITY || !accept)) begin
                accept = 1'b1;
                sel_vc = VC_W'(v);
            end else begin
                accept = accept;
            end
        end
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            if (sel_vc == VC_W'(v)) begin
                win_idx = cand_idx[v];
            end else begin
                win_idx = win_idx;
            end
        end
        for (int i = 0; i < N_INPUTS; i++) begin
            if (win_idx == IW'(i)) begin
                win_flit = fin_req_i[i];
            end else begin
                win_flit = win_flit;
            end
        end
        win_head   = flit_is_head(win_flit.fdata);
        win_tail   = flit_is_tail(win_flit.fdata);
        win_single = flit_is_single(win_flit.fdata);
    end

    // Ready strobes, arbiter pointer updates and credit bookkeeping strobes.
    always_comb begin
        for (int i = 0; i < N_INPUTS; i++) begin
            fin_resp_o[i].ready = accept && !arst && (win_idx == IW'(i));
        end
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            credit_dec[v] = accept && (sel_vc == VC_W'(v));
            arb_update[v] = credit_dec[v] && win_head && !lock[v].locked;
            overflow[v]   = credit_i[v] && !credit_dec[v]
                          && (credit[v] == CW'(CREDIT_DEPTH));
        end
    end

    // Credit counters; an increment at full depth saturates.
    always_ff @(posedge clk) begin
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            if (arst) begin
                credit[v] <= CW'(CREDIT_DEPTH);
            end else begin
                case ({credit_i[v], credit_dec[v]})
                    2'b10: begin
                        if (overflow[v]) begin
                            credit[v] <= credit[v];
                        end else begin
                            credit[v] <= credit[v] + CW'(1);
                        end
                    end
                    2'b01:   credit[v] <= credit[v] - CW'(1);
                    default: credit[v] <= credit[v];
                endcase
            end
        end
    end

    // Wormhole locks: opened by a multi-flit head, released by the owner's tail.
    always_ff @(posedge clk) begin
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            if (arst) begin
                lock[v] <= '0;
            end else if (credit_dec[v]) begin
                if (lock[v].locked) begin
                    if (win_tail) begin
                        lock[v] <= '0;
                    end else begin
                        lock[v] <= lock[v];
                    end
                end else if (win_head && !win_single) begin
                    lock[v] <= '{locked: 1'b1, owner: OWNER_WIDTH'(win_idx)};
                end else begin
                    lock[v] <= lock[v];
                end
            end else begin
                lock[v] <= lock[v];
            end
        end
    end

    // Registered output flit and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (arst) begin
            fout_req_o   <= '0;
            credit_err_o <= 1'b0;
        end else begin
            credit_err_o <= credit_err_o | (|overflow);
            if (accept) begin
                fout_req_o       <= win_flit;
                fout_req_o.vc_id <= VC_WIDTH'(sel_vc);
            end else begin
                fout_req_o <= '0;
            end
        end
    end

endmodule
